// File: rtl/mem_access_pkg.sv
// Shared types and defaults for the 8x4 memory access controller.
// MEM_ACCESS_VERIFY_EN adds the post-write read-back check state.
package mem_access_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 4;
    localparam int DEPTH_DEF  = 8;
    localparam int LEN_W_DEF  = 3;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_WAIT = 3'd1,
        S_WR_DO   = 3'd2,
`ifdef MEM_ACCESS_VERIFY_EN
        S_WR_CHK  = 3'd3,
`endif
        S_RD_ADDR = 3'd4,
        S_RD_CAP  = 3'd5,
        S_RD_HOLD = 3'd6
    } state_e;

endpackage

// File: rtl/mem_burst_addr_gen.sv
// Burst address/beat counter: load start+len, step with DEPTH wrap.
// The address register doubles as the registered memory address.
module mem_burst_addr_gen
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int LEN_WIDTH  = LEN_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] start_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic                  step_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    localparam logic [ADDR_WIDTH-1:0] WRAP_AT = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] cur_q, cur_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;

    always_comb begin
        cur_d = cur_q;
        cnt_d = cnt_q;
        if (load_i) begin
            cur_d = start_i;
            cnt_d = len_i;
        end else if (step_i) begin
            cur_d = (cur_q == WRAP_AT) ? '0 : cur_q + ADDR_WIDTH'(1);
            cnt_d = cnt_q - LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q <= '0;
            cnt_q <= '0;
        end else begin
            cur_q <= cur_d;
            cnt_q <= cnt_d;
        end
    end

    assign addr_o = cur_q;
    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/mem8x4_access_ctrl.sv
// Burst read/write initiator for the 8x4 memory port, valid/ready on all sides.
// Define MEM_ACCESS_VERIFY_EN for read-back verification of each written word.
module mem8x4_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int LEN_WIDTH  = LEN_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef MEM_ACCESS_VERIFY_EN
    ,
    output logic                  verify_err
`endif
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  we_q, we_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic                  err_q, err_d;
    logic                  load, step;
    logic                  last_beat;
    logic                  addr_bad;
`ifdef MEM_ACCESS_VERIFY_EN
    logic                  verr_q, verr_d;
`endif

    // Extra bit keeps the range check meaningful when DEPTH == 2**ADDR_WIDTH
    assign addr_bad = ({1'b0, cmd_addr} >= (ADDR_WIDTH + 1)'(DEPTH));

    mem_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .start_i (cmd_addr),
        .len_i   (cmd_len),
        .step_i  (step),
        .addr_o  (mem_addr),
        .last_o  (last_beat)
    );

    always_comb begin
        state_d  = state_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        we_d     = 1'b0;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;
        err_d    = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
`ifdef MEM_ACCESS_VERIFY_EN
        verr_d   = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (addr_bad) begin
                        err_d = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = (cmd_write == CMD_RD) ? S_RD_ADDR
                                                        : S_WR_WAIT;
                    end
                end
            end
            S_WR_WAIT: begin
                if (wr_valid) begin
                    wdata_d = wr_data;
                    we_d    = 1'b1;
                    state_d = S_WR_DO;
                end
            end
            S_WR_DO: begin
`ifdef MEM_ACCESS_VERIFY_EN
                state_d = S_WR_CHK;
`else
                step    = 1'b1;
                state_d = last_beat ? S_IDLE : S_WR_WAIT;
`endif
            end
`ifdef MEM_ACCESS_VERIFY_EN
            S_WR_CHK: begin
                verr_d  = (mem_rdata != wdata_q);
                step    = 1'b1;
                state_d = last_beat ? S_IDLE : S_WR_WAIT;
            end
`endif
            S_RD_ADDR: begin
                rdata_d  = mem_rdata;
                rvalid_d = 1'b1;
                rlast_d  = last_beat;
                state_d  = S_RD_CAP;
            end
            S_RD_CAP, S_RD_HOLD: begin
                if (rd_ready) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    step     = 1'b1;
                    state_d  = last_beat ? S_IDLE : S_RD_ADDR;
                end else begin
                    state_d  = S_RD_HOLD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wdata_q  <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            err_q    <= err_d;
        end
    end

`ifdef MEM_ACCESS_VERIFY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) verr_q <= 1'b0;
        else        verr_q <= verr_d;
    end
    assign verify_err = verr_q;
`endif

    assign cmd_ready = (state_q == S_IDLE);
    assign wr_ready  = (state_q == S_WR_WAIT);
    assign busy      = (state_q != S_IDLE);
    assign rd_valid  = rvalid_q;
    assign rd_data   = rdata_q;
    assign rd_last   = rlast_q;
    assign err       = err_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;

endmodule
